// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART receive FSM encodings and default framing constants
package uart_rx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int UART_DEF_CLKS_PER_BIT = 16;
    localparam int UART_DEF_DATA_BITS    = 8;
    localparam int UART_DEF_FIFO_DEPTH   = 16;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through FIFO with occupancy, full/empty and overrun pulse
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push & full & ~pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a FWFT receive FIFO; UART_RX_PARITY_EN adds a parity bit
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DEF_DATA_BITS,
    parameter int FIFO_DEPTH   = UART_DEF_FIFO_DEPTH,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RXD,
    input  logic                          RD_EN,
    output logic [DATA_BITS-1:0]          RD_DATA,
    output logic                          EMPTY,
    output logic                          FULL,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN,
    output logic                          PARITY_ERR
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    CNT_LAST  = 4'(DATA_BITS - 1);

    uart_state_t          state;
    logic                 rxd_meta;
    logic                 rxd_sync;
    logic                 armed;
    logic [TW-1:0]        timer;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 push;
    logic                 frame_err;
    logic                 parity_err;
    logic                 par_bad;

`ifndef UART_RX_PARITY_EN
    // Parity sense has no effect when frames carry no parity bit.
    localparam logic PARITY_SENSE = (PARITY_ODD != 0);
    assign par_bad = PARITY_SENSE & 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_sync <= rxd_meta;
        end
    end

    // armed records that the line was seen high in IDLE, so only a real
    // 1->0 transition starts a frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            timer      <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            push       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
`endif
        end else begin
            push       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                    if (rxd_sync) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        state <= rxd_sync ? ST_IDLE : ST_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        shift <= {rxd_sync, shift[DATA_BITS-1:1]};
                        if (bit_cnt == CNT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (timer == BIT_LAST) begin
                        timer   <= '0;
                        par_bad <= ((^shift) ^ rxd_sync) != (PARITY_ODD != 0);
                        state   <= ST_STOP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        state <= ST_IDLE;
                        if (!rxd_sync) begin
                            frame_err <= 1'b1;
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                        end else begin
                            push <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign FRAME_ERR  = frame_err;
    assign PARITY_ERR = parity_err;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (push),
        .push_data (shift),
        .pop       (RD_EN),
        .pop_data  (RD_DATA),
        .empty     (EMPTY),
        .full      (FULL),
        .count     (COUNT),
        .overrun   (OVERRUN)
    );

endmodule
